// File: rtl/vlsu_pkg.sv
// vlsu_pkg: shared types for the VLSU mask arbiter.
//   strb_t           - mask bits carried by one lane for one beat (DLEN/4 bits)
//   beats_t          - mask-beat count of one instruction (0..MaxBeats)
//   mask_arb_state_e - arbiter FSM state
//   ord_entry_t      - one order-FIFO entry {is_load, vm, beats}
package vlsu_pkg;

    localparam int unsigned DLEN     = 32;
    localparam int unsigned MaxBeats = 256;

    typedef logic [DLEN/4-1:0]                strb_t;
    typedef logic [$clog2(MaxBeats+1)-1:0]    beats_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STORE
    } mask_arb_state_e;

    typedef struct packed {
        logic   is_load;
        logic   vm;
        beats_t beats;
    } ord_entry_t;

    // Unmasked instructions, and masked ones with zero beats, take nothing
    // from the mask stream; the arbiter just drops them from the queue.
    function automatic logic skip_entry(input ord_entry_t e);
        return e.vm || (e.beats == '0);
    endfunction

endpackage

// File: rtl/vlsu_mask_arb_if.sv
// vlsu_mask_arb_if: bundle of all handshake/bus signals of the mask arbiter.
//   ord_*      - order entries from the control machine
//   mask_*     - per-lane mask beats in, broadcast consume strobe out
//   ld_mask_*  - mask stream to the load unit
//   st_mask_*  - mask stream to the store unit
//   busy_o     - arbiter has queued or in-flight work
// Modports: slave = arbiter side, master = environment side.
interface vlsu_mask_arb_if #(
    parameter int unsigned NrLanes = 4
) ();
    import vlsu_pkg::*;

    logic                      ord_valid_i;
    logic                      ord_ready_o;
    logic                      ord_is_load_i;
    logic                      ord_vm_i;
    beats_t                    ord_beats_i;

    logic [NrLanes-1:0]        mask_valid_i;
    strb_t [NrLanes-1:0]       mask_bits_i;
    logic                      mask_ready_o;

    logic                      ld_mask_valid_o;
    logic                      ld_mask_ready_i;
    strb_t [NrLanes-1:0]       ld_mask_bits_o;

    logic                      st_mask_valid_o;
    logic                      st_mask_ready_i;
    strb_t [NrLanes-1:0]       st_mask_bits_o;

    logic                      busy_o;

    modport slave (
        input  ord_valid_i, ord_is_load_i, ord_vm_i, ord_beats_i,
        input  mask_valid_i, mask_bits_i,
        input  ld_mask_ready_i, st_mask_ready_i,
        output ord_ready_o, mask_ready_o,
        output ld_mask_valid_o, ld_mask_bits_o,
        output st_mask_valid_o, st_mask_bits_o,
        output busy_o
    );

    modport master (
        output ord_valid_i, ord_is_load_i, ord_vm_i, ord_beats_i,
        output mask_valid_i, mask_bits_i,
        output ld_mask_ready_i, st_mask_ready_i,
        input  ord_ready_o, mask_ready_o,
        input  ld_mask_valid_o, ld_mask_bits_o,
        input  st_mask_valid_o, st_mask_bits_o,
        input  busy_o
    );

endinterface

// File: rtl/vlsu_mask_ord_fifo.sv
// vlsu_mask_ord_fifo: order FIFO of {is_load, vm, beats} entries.
//   clk_i, rst_ni - clock, async active-low reset (pointers only)
//   push_i/full_o - write side; push ignored while full
//   data_i        - entry to write
//   pop_i/empty_o - read side; pop ignored while empty
//   head_o        - oldest entry (valid when !empty_o)
// No flow-through: a pushed entry appears at head_o the next cycle.
module vlsu_mask_ord_fifo
    import vlsu_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    output logic       full_o,
    input  ord_entry_t data_i,
    input  logic       pop_i,
    output logic       empty_o,
    output ord_entry_t head_o
);

    localparam int unsigned AW = $clog2(Depth);

    // One extra pointer bit separates full (MSBs differ) from empty (equal).
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    ord_entry_t  mem_q [Depth];
    logic        do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/vlsu_mask_arb.sv
// vlsu_mask_arb: routes the shared per-lane mask stream to the load or store
// unit in instruction issue order.
//   clk_i, rst_ni - clock, async active-low reset
//   bus (slave)   - order handshake, lane mask inputs + consume strobe,
//                   load/store mask handshakes, busy
// An order FIFO remembers issue order; a three-state FSM pops one entry,
// then forwards exactly 'beats' mask beats to the selected unit. The mask
// path is purely combinational: the lanes hold their beat until consumed.
module vlsu_mask_arb
    import vlsu_pkg::*;
#(
    parameter int unsigned NrLanes  = 4,
    parameter int unsigned OrdDepth = 4,
    parameter int unsigned MaxBeats = 256
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    vlsu_mask_arb_if.slave bus
);

    mask_arb_state_e    state_q, state_d;
    beats_t             cnt_q, cnt_d;
    logic               full, empty, pop;
    logic               ld_valid, st_valid, fire;
    logic [NrLanes-1:0] lane_valid;
    ord_entry_t         push_entry, head;

    assign lane_valid = bus.mask_valid_i;
    assign push_entry = '{is_load: bus.ord_is_load_i,
                          vm:      bus.ord_vm_i,
                          beats:   bus.ord_beats_i};

    vlsu_mask_ord_fifo #(.Depth(OrdDepth)) i_ord_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (bus.ord_valid_i),
        .full_o (full),
        .data_i (push_entry),
        .pop_i  (pop),
        .empty_o(empty),
        .head_o (head)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        ld_valid = 1'b0;
        st_valid = 1'b0;
        fire     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Dispatch cycle: never forwards a beat.
                if (!empty) begin
                    pop = 1'b1;
                    if (!skip_entry(head)) begin
                        cnt_d   = head.beats;
                        state_d = head.is_load ? LOAD : STORE;
                    end
                end
            end
            LOAD: begin
                ld_valid = &lane_valid;
                fire     = ld_valid && bus.ld_mask_ready_i;
            end
            STORE: begin
                st_valid = &lane_valid;
                fire     = st_valid && bus.st_mask_ready_i;
            end
            default: state_d = IDLE;
        endcase
        if (fire) begin
            cnt_d = cnt_q - beats_t'(1);
            if (cnt_q == beats_t'(1)) state_d = IDLE;
        end
    end

    assign bus.ord_ready_o     = !full;
    assign bus.mask_ready_o    = fire;
    assign bus.ld_mask_valid_o = ld_valid;
    assign bus.st_mask_valid_o = st_valid;
    assign bus.ld_mask_bits_o  = bus.mask_bits_i;
    assign bus.st_mask_bits_o  = bus.mask_bits_i;
    assign bus.busy_o          = (state_q != IDLE) || !empty;

    a_beats_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.ord_valid_i && !full) |-> (32'(bus.ord_beats_i) <= MaxBeats));

    a_ready_needs_lanes: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.mask_ready_o |-> (&lane_valid));

endmodule
